// File: rtl/mul_div_unit_if.sv
// rtl/mul_div_unit_if.sv - start/done handshake, operands and result of the multiply/divide unit
interface mul_div_unit_if;
  logic        start;
  logic        op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [63:0] result;

  modport master (output start, op, a, b, input busy, done, div_by_zero, result);
  modport slave  (input start, op, a, b, output busy, done, div_by_zero, result);
endinterface

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - radix-2 Booth multiplier and restoring divider sharing one 32-step iteration
module mul_div_unit (
  input logic           clock,
  input logic           clear,
  mul_div_unit_if.slave bus
);
  typedef enum logic [2:0] {IDLE, PREP, RUN, FIX, DONE} state_t;

  state_t      state;
  logic        is_div;
  logic        busy_q;
  logic        done_q;
  logic        dbz_q;
  logic [63:0] result_q;
  logic [31:0] a_reg;
  logic [31:0] b_reg;
  logic [65:0] prod;
  logic [31:0] rem;
  logic [31:0] quo;
  logic [31:0] dvs;
  logic        q_neg;
  logic        r_neg;
  logic [4:0]  count;

  logic [32:0] a_ext;
  logic [32:0] acc_new;
  logic [65:0] prod_next;
  logic [32:0] shifted;
  logic [32:0] trial;
  logic [31:0] rem_next;
  logic [31:0] quo_next;
  logic [31:0] a_mag;
  logic [31:0] b_mag;

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.result      = result_q;

  // prod = {33-bit accumulator, multiplier, appended Booth bit}; the extra accumulator bit keeps -2^31 exact
  always_comb begin
    a_ext = {a_reg[31], a_reg};
    case (prod[1:0])
      2'b01:   acc_new = prod[65:33] + a_ext;
      2'b10:   acc_new = prod[65:33] - a_ext;
      default: acc_new = prod[65:33];
    endcase
    prod_next = {acc_new[32], acc_new, prod[32:1]};

    shifted = {rem, quo[31]};
    trial   = shifted - {1'b0, dvs};
    if (trial[32]) begin
      rem_next = shifted[31:0];
      quo_next = {quo[30:0], 1'b0};
    end else begin
      rem_next = trial[31:0];
      quo_next = {quo[30:0], 1'b1};
    end

    a_mag = a_reg[31] ? (~a_reg + 32'd1) : a_reg;
    b_mag = b_reg[31] ? (~b_reg + 32'd1) : b_reg;
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state    <= IDLE;
      is_div   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
      result_q <= 64'h0;
      a_reg    <= 32'h0;
      b_reg    <= 32'h0;
      prod     <= 66'h0;
      rem      <= 32'h0;
      quo      <= 32'h0;
      dvs      <= 32'h0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      count    <= 5'd0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            is_div <= bus.op;
            a_reg  <= bus.a;
            b_reg  <= bus.b;
            dbz_q  <= 1'b0;
            if (bus.op && (bus.b == 32'h0)) begin
              result_q <= {bus.a, 32'hFFFF_FFFF};
              dbz_q    <= 1'b1;
              done_q   <= 1'b1;
              state    <= DONE;
            end else begin
              busy_q <= 1'b1;
              state  <= PREP;
            end
          end else if (state == DONE) begin
            state <= IDLE;
          end
        end
        PREP: begin
          prod  <= {33'h0, b_reg, 1'b0};
          rem   <= 32'h0;
          quo   <= a_mag;
          dvs   <= b_mag;
          q_neg <= a_reg[31] ^ b_reg[31];
          r_neg <= a_reg[31];
          count <= 5'd0;
          state <= RUN;
        end
        RUN: begin
          if (is_div) begin
            rem <= rem_next;
            quo <= quo_next;
          end else begin
            prod <= prod_next;
          end
          count <= count + 5'd1;
          if (count == 5'd31) state <= FIX;
        end
        FIX: begin
          // quotient truncates toward zero, remainder follows the dividend; -2^31/-1 wraps silently
          if (is_div)
            result_q <= {(r_neg ? (~rem + 32'd1) : rem), (q_neg ? (~quo + 32'd1) : quo)};
          else
            result_q <= prod[64:1];
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state  <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - scoreboard bench for mul_div_unit
module tb_mul_div_unit;
  logic clock = 1'b0;
  logic clear;

  always #5 clock = ~clock;

  mul_div_unit_if bus ();

  mul_div_unit dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  typedef struct {
    logic [63:0] res;
    logic        dbz;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic logic [63:0] model(input logic op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0]        ax;
    logic [63:0]        bx;
    logic signed [31:0] q;
    logic signed [31:0] r;
    if (!op) begin
      ax = {{32{a[31]}}, a};
      bx = {{32{b[31]}}, b};
      return ax * bx;
    end
    if (b == 32'h0) return {a, 32'hFFFF_FFFF};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
    q = $signed(a) / $signed(b);
    r = $signed(a) % $signed(b);
    return {r, q};
  endfunction

  task automatic issue(input logic op, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] res, input logic dbz, input int lat);
    exp_t e;
    e.res = res;
    e.dbz = dbz;
    e.lat = lat;
    sb.push_back(e);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    bus.op    = ~op;
    bus.a     = $urandom;
    bus.b     = $urandom;
  endtask

  task automatic wait_done(output logic [63:0] res, output logic dbz, output int lat);
    lat = 0;
    while (bus.done !== 1'b1 && lat < 100) begin
      @(posedge clock);
      #1;
      lat++;
    end
    if (bus.done !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: done=%b after %0d edges, required 1", bus.done, lat);
    end
    res = bus.result;
    dbz = bus.div_by_zero;
  endtask

  task automatic test_reset();
    clear     = 1'b1;
    bus.start = 1'b0;
    bus.op    = 1'b0;
    bus.a     = 32'h0;
    bus.b     = 32'h0;
    repeat (2) @(posedge clock);
    #1;
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b required 0", bus.busy); end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b required 0", bus.done); end
    n_checks++; if (bus.div_by_zero !== 1'b0) begin n_fail++; $display("FAIL reset_dbz got %b required 0", bus.div_by_zero); end
    n_checks++; if (bus.result !== 64'h0) begin n_fail++; $display("FAIL reset_result got %h required 0", bus.result); end
    @(negedge clock);
    clear = 1'b0;
    @(posedge clock);
    #1;
  endtask

  task automatic test_mul();
    logic [31:0] av [6] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0};
    logic [31:0] bv [6] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0};
    logic [63:0] ev [6] = '{64'hFFFF_FFFF_FFFF_FFEB, 64'h4000_0000_0000_0000, 64'h1, 64'h0, 64'h0, 64'h0};
    logic [63:0] res;
    logic        dbz;
    int          lat;
    exp_t        e;
    for (int i = 3; i < 6; i++) begin
      av[i] = $urandom;
      bv[i] = $urandom;
      ev[i] = model(1'b0, av[i], bv[i]);
    end
    for (int i = 0; i < 6; i++) begin
      issue(1'b0, av[i], bv[i], ev[i], 1'b0, 34);
      n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL mul_busy[%0d] got %b required 1", i, bus.busy); end
      wait_done(res, dbz, lat);
      e = sb.pop_front();
      n_checks++; if (res !== e.res) begin n_fail++; $display("FAIL mul_result[%0d] %h*%h got %h required %h", i, av[i], bv[i], res, e.res); end
      n_checks++; if (dbz !== e.dbz) begin n_fail++; $display("FAIL mul_dbz[%0d] got %b required %b", i, dbz, e.dbz); end
      n_checks++; if (lat !== e.lat) begin n_fail++; $display("FAIL mul_latency[%0d] got %0d required %0d", i, lat, e.lat); end
    end
  endtask

  task automatic test_div();
    logic [31:0] av [7] = '{32'd17, 32'hFFFF_FFEF, 32'h8000_0000, 32'd100, 32'h0, 32'h0, 32'h0};
    logic [31:0] bv [7] = '{32'hFFFF_FFFB, 32'd5, 32'hFFFF_FFFF, 32'd7, 32'h0, 32'h0, 32'h0};
    logic [63:0] ev [7] = '{64'h0000_0002_FFFF_FFFD, 64'hFFFF_FFFE_FFFF_FFFD, 64'h0000_0000_8000_0000,
                            64'h0000_0002_0000_000E, 64'h0, 64'h0, 64'h0};
    logic [63:0] res;
    logic        dbz;
    int          lat;
    exp_t        e;
    for (int i = 4; i < 7; i++) begin
      av[i] = $urandom;
      bv[i] = (i == 6) ? ($urandom & 32'h8000_00FF) | 32'h1 : $urandom | 32'h1;
      ev[i] = model(1'b1, av[i], bv[i]);
    end
    for (int i = 0; i < 7; i++) begin
      issue(1'b1, av[i], bv[i], ev[i], 1'b0, 34);
      wait_done(res, dbz, lat);
      e = sb.pop_front();
      n_checks++; if (res !== e.res) begin n_fail++; $display("FAIL div_result[%0d] %h/%h got %h required %h", i, av[i], bv[i], res, e.res); end
      n_checks++; if (dbz !== e.dbz) begin n_fail++; $display("FAIL div_dbz[%0d] got %b required %b", i, dbz, e.dbz); end
      n_checks++; if (lat !== e.lat) begin n_fail++; $display("FAIL div_latency[%0d] got %0d required %0d", i, lat, e.lat); end
    end
  endtask

  task automatic test_div_by_zero();
    logic [63:0] res;
    logic        dbz;
    int          lat;
    exp_t        e;
    issue(1'b1, 32'd5, 32'd0, 64'h0000_0005_FFFF_FFFF, 1'b1, 0);
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL dbz_busy got %b required 0", bus.busy); end
    wait_done(res, dbz, lat);
    e = sb.pop_front();
    n_checks++; if (res !== e.res) begin n_fail++; $display("FAIL dbz_result got %h required %h", res, e.res); end
    n_checks++; if (dbz !== e.dbz) begin n_fail++; $display("FAIL dbz_flag got %b required %b", dbz, e.dbz); end
    n_checks++; if (lat !== e.lat) begin n_fail++; $display("FAIL dbz_latency got %0d required %0d", lat, e.lat); end
    @(posedge clock);
    #1;
    n_checks++; if (bus.div_by_zero !== 1'b1) begin n_fail++; $display("FAIL dbz_hold got %b required 1", bus.div_by_zero); end
    issue(1'b0, 32'd2, 32'd3, 64'd6, 1'b0, 34);
    n_checks++; if (bus.div_by_zero !== 1'b0) begin n_fail++; $display("FAIL dbz_clear_on_start got %b required 0", bus.div_by_zero); end
    wait_done(res, dbz, lat);
    e = sb.pop_front();
    n_checks++; if (res !== e.res) begin n_fail++; $display("FAIL after_dbz_result got %h required %h", res, e.res); end
    n_checks++; if (dbz !== e.dbz) begin n_fail++; $display("FAIL after_dbz_flag got %b required %b", dbz, e.dbz); end
    n_checks++; if (lat !== e.lat) begin n_fail++; $display("FAIL after_dbz_latency got %0d required %0d", lat, e.lat); end
  endtask

  task automatic test_ignore_and_clear();
    logic [63:0] res;
    logic        dbz;
    int          lat;
    exp_t        e;
    issue(1'b0, 32'd5, 32'hFFFF_FFFA, 64'hFFFF_FFFF_FFFF_FFE2, 1'b0, 34);
    repeat (9) begin
      @(posedge clock);
      #1;
    end
    bus.start = 1'b1;
    bus.op    = 1'b1;
    bus.a     = 32'd1000;
    bus.b     = 32'd0;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    n_checks++; if (bus.div_by_zero !== 1'b0 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL ignore_side_effect busy=%b dbz=%b required busy=1 dbz=0", bus.busy, bus.div_by_zero); end
    wait_done(res, dbz, lat);
    e = sb.pop_front();
    n_checks++; if (res !== e.res) begin n_fail++; $display("FAIL ignore_result got %h required %h", res, e.res); end
    n_checks++; if (lat + 10 !== e.lat) begin n_fail++; $display("FAIL ignore_latency got %0d required %0d", lat + 10, e.lat); end

    bus.start = 1'b1;
    bus.op    = 1'b1;
    bus.a     = 32'd77;
    bus.b     = 32'd3;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    repeat (20) begin
      @(posedge clock);
      #1;
    end
    n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL clear_pre_busy got %b required 1", bus.busy); end
    #2;
    clear = 1'b1;
    #2;
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL clear_busy got %b required 0", bus.busy); end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL clear_done got %b required 0", bus.done); end
    n_checks++; if (bus.result !== 64'h0) begin n_fail++; $display("FAIL clear_result got %h required 0", bus.result); end
    n_checks++; if (bus.div_by_zero !== 1'b0) begin n_fail++; $display("FAIL clear_dbz got %b required 0", bus.div_by_zero); end
    #1;
    clear = 1'b0;
    @(posedge clock);
    #1;
    n_checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin n_fail++; $display("FAIL clear_idle busy=%b done=%b required 0 0", bus.busy, bus.done); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] res;
    logic        dbz;
    int          lat;
    exp_t        e;
    issue(1'b1, 32'd100, 32'd7, 64'h0000_0002_0000_000E, 1'b0, 34);
    wait_done(res, dbz, lat);
    e = sb.pop_front();
    n_checks++; if (res !== e.res) begin n_fail++; $display("FAIL b2b_first_result got %h required %h", res, e.res); end
    n_checks++; if (lat !== e.lat) begin n_fail++; $display("FAIL b2b_first_latency got %0d required %0d", lat, e.lat); end
    issue(1'b0, 32'd3, 32'd4, 64'd12, 1'b0, 34);
    n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept busy=%b required 1", bus.busy); end
    wait_done(res, dbz, lat);
    e = sb.pop_front();
    n_checks++; if (res !== e.res) begin n_fail++; $display("FAIL b2b_second_result got %h required %h", res, e.res); end
    n_checks++; if (dbz !== e.dbz) begin n_fail++; $display("FAIL b2b_second_dbz got %b required %b", dbz, e.dbz); end
    n_checks++; if (lat !== e.lat) begin n_fail++; $display("FAIL b2b_second_latency got %0d required %0d", lat, e.lat); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_div_by_zero();
    test_ignore_and_clear();
    test_back_to_back();
    n_checks++;
    if (sb.size() !== 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain got %0d entries required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
